// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Sequencer for bit-serial addition of two WIDTH-bit operands. Both
//   operands are latched on an accepted start. They are shifted LSB-first
//   through a single-bit full adder with a carry register. The sum bits are
//   collected in a result shift register and published on completion.
//
//   Optional build macro: SERIAL_ADD_SUB_EN
//     Adds a 'sub' input. When sub=1, the module computes op_a - op_b by
//     loading ~op_b and setting the initial carry to 1. In that mode cout=1
//     means no borrow.
//
//   Ports
//     clk, reset       rising-edge clock, async active-high reset
//     start, abort     request (accepted only when idle) / synchronous cancel
//     sub              (SERIAL_ADD_SUB_EN only) subtract select, sampled on accept
//     op_a, op_b       operands, sampled in the accept cycle
//     busy             high while an operation is in SHIFT or DONE
//     done             one-cycle pulse: sum/cout valid
//     sum, cout        registered result, held until the next completion
//     ser_a, ser_b,    serial adder taps for debug; these are 0 outside SHIFT
//     ser_sum
module serial_add_ctrl #(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ser_a,
    output logic             ser_b,
    output logic             ser_sum
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             accept;
    logic             last;
    logic             carry_nxt;
    logic [WIDTH-1:0] load_b;
    logic             carry_init;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: a + ~b + 1.
    assign load_b     = sub ? ~op_b : op_b;
    assign carry_init = sub;
`else
    assign load_b     = op_b;
    assign carry_init = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and outputs
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        ser_a     = 1'b0;
        ser_b     = 1'b0;
        ser_sum   = 1'b0;
        case (state)
            IDLE: begin
                // abort wins over a simultaneous start
                if (start && !abort) begin
                    accept    = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                ser_a   = a_sr[0];
                ser_b   = b_sr[0];
                ser_sum = a_sr[0] ^ b_sr[0] ^ carry;
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Outputs are already committed, so done pulses even under abort.
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign carry_nxt = (ser_a & ser_b) | (carry & (ser_a ^ ser_b));

    // Serial datapath and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            a_sr  <= op_a;
            b_sr  <= load_b;
            carry <= carry_init;
            cnt   <= '0;
        end else if (state == SHIFT) begin
            if (abort) begin
                carry <= 1'b0;
                cnt   <= '0;
            end else begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                res_sr <= {ser_sum, res_sr[WIDTH-1:1]};
                carry  <= carry_nxt;
                cnt    <= cnt + 1'b1;
                // Publish on entry to DONE. The result shift register update
                // is not visible until next cycle, so build the word here.
                if (last) begin
                    sum_q  <= {ser_sum, res_sr[WIDTH-1:1]};
                    cout_q <= carry_nxt;
                end
            end
        end else if (state == DONE) begin
            carry <= 1'b0;
            cnt   <= '0;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
